// File: rtl/fetch_align.sv
// Fetch stage between prefetch and decode: owns the fetch PC and a one-entry output buffer.
// FETCH_COMP_EN enables 16-bit instruction support; undefined, halfword redirects raise a misalign fault.
module fetch_align #(
  parameter logic [31:0] PC_RESET  = 32'h8000_0000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pf_instr_i,
  input  logic        pf_ack_i,
  input  logic        pf_stall_i,
  output logic        instr_req_o,
  output logic [31:0] pc_ff_o,
  output logic        is_comp_o,
  output logic        clear_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_comp_o,
  output logic        id_misalign_o
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_FLUSH, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;
  logic        comp_q, comp_d;
  logic        mis_q, mis_d;

  logic        is_comp;
  logic        redir_fault;
  logic        accept;
  logic [31:0] redir_tgt;

  assign redir_tgt = redirect_pc_i & ~32'd1;

`ifdef FETCH_COMP_EN
  assign is_comp     = pf_ack_i & (pf_instr_i[1:0] != 2'b11);
  assign redir_fault = 1'b0;
`else
  assign is_comp     = 1'b0;
  assign redir_fault = redirect_pc_i[1];
`endif

  // Decode must have room (empty buffer or draining this cycle) before a new instruction lands.
  assign accept = (state_q == S_FETCH) & pf_ack_i & ~pf_stall_i &
                  (~vld_q | id_ready_i) & ~redirect_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vld_d       = vld_q;
    instr_d     = instr_q;
    idpc_d      = idpc_q;
    comp_d      = comp_q;
    mis_d       = mis_q;
    instr_req_o = 1'b0;
    clear_o     = 1'b0;

    case (state_q)
      S_RESET: begin
        clear_o = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: instr_req_o = 1'b1;
      S_FLUSH: begin
        clear_o = 1'b1;
        state_d = S_FETCH;
      end
      default: ;
    endcase

    if (redirect_i) begin
      pc_d = redir_tgt;
      if (redir_fault) begin
        // The fault itself is delivered through the buffer so decode raises the trap in order.
        vld_d   = 1'b1;
        instr_d = INSTR_NOP;
        idpc_d  = redirect_pc_i;
        comp_d  = 1'b0;
        mis_d   = 1'b1;
        state_d = S_FAULT;
      end else begin
        vld_d   = 1'b0;
        instr_d = INSTR_NOP;
        mis_d   = 1'b0;
        state_d = S_FLUSH;
      end
    end else if (accept) begin
      vld_d   = 1'b1;
      instr_d = pf_instr_i;
      idpc_d  = pc_q;
      comp_d  = is_comp;
      mis_d   = 1'b0;
      pc_d    = pc_q + (is_comp ? 32'd2 : 32'd4);
    end else if (vld_q & id_ready_i) begin
      vld_d   = 1'b0;
      instr_d = INSTR_NOP;
      mis_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= PC_RESET;
      vld_q   <= 1'b0;
      instr_q <= INSTR_NOP;
      idpc_q  <= PC_RESET;
      comp_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      comp_q  <= comp_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_ff_o       = pc_q;
  assign is_comp_o     = is_comp;
  assign id_valid_o    = vld_q;
  assign id_instr_o    = instr_q;
  assign id_pc_o       = idpc_q;
  assign id_comp_o     = comp_q;
  assign id_misalign_o = mis_q;

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align; expectations adapt to whether FETCH_COMP_EN is defined.
module tb_fetch_align;

`ifdef FETCH_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pf_instr_i;
  logic        pf_ack_i, pf_stall_i;
  logic        instr_req_o, is_comp_o, clear_o;
  logic [31:0] pc_ff_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i, id_valid_o, id_comp_o, id_misalign_o;
  logic [31:0] id_instr_o, id_pc_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] pc2;

  fetch_align dut (
    .clk(clk), .rst(rst),
    .pf_instr_i(pf_instr_i), .pf_ack_i(pf_ack_i), .pf_stall_i(pf_stall_i),
    .instr_req_o(instr_req_o), .pc_ff_o(pc_ff_o), .is_comp_o(is_comp_o),
    .clear_o(clear_o), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_comp_o(id_comp_o), .id_misalign_o(id_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pf_instr_i = 32'h0; pf_ack_i = 1'b0; pf_stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
    pc2 = COMP ? 32'h8000_0006 : 32'h8000_0008;
    #12;
    chk("rst_pc", pc_ff_o, 32'h8000_0000);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_instr", id_instr_o, NOP);
    chk("rst_idpc", id_pc_o, 32'h8000_0000);
    chk("rst_comp_mis", {30'b0, id_comp_o, id_misalign_o}, 32'd0);
    chk("rst_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);

    @(posedge clk); #1; rst = 1'b0;
    chk("sreset_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);
    step();
    chk("fetch_clr_req", {30'b0, clear_o, instr_req_o}, 32'b01);
    chk("fetch_pc", pc_ff_o, 32'h8000_0000);
    chk("fetch_valid", {31'b0, id_valid_o}, 32'd0);

    // two back-to-back instructions, 32-bit then 16-bit
    pf_ack_i = 1'b1; pf_instr_i = 32'h00A0_0093; id_ready_i = 1'b1;
    #1 chk("iscomp_32", {31'b0, is_comp_o}, 32'd0);
    step();
    $display("txn acc instr=%h id_pc=%h pc=%h", id_instr_o, id_pc_o, pc_ff_o);
    chk("a1_valid", {31'b0, id_valid_o}, 32'd1);
    chk("a1_instr", id_instr_o, 32'h00A0_0093);
    chk("a1_idpc", id_pc_o, 32'h8000_0000);
    chk("a1_pc", pc_ff_o, 32'h8000_0004);
    pf_instr_i = 32'h0000_4501;
    #1 chk("iscomp_16", {31'b0, is_comp_o}, {31'b0, COMP});
    step();
    $display("txn acc instr=%h id_pc=%h pc=%h", id_instr_o, id_pc_o, pc_ff_o);
    chk("a2_instr", id_instr_o, 32'h0000_4501);
    chk("a2_idpc", id_pc_o, 32'h8000_0004);
    chk("a2_comp", {31'b0, id_comp_o}, {31'b0, COMP});
    chk("a2_pc", pc_ff_o, pc2);

    // backpressure: buffer full, decode not ready
    id_ready_i = 1'b0; pf_instr_i = 32'h0020_8113;
    for (int i = 0; i < 2; i++) begin
      step();
      $display("txn hold cycle=%0d instr=%h pc=%h", i, id_instr_o, pc_ff_o);
      chk("hold_instr", id_instr_o, 32'h0000_4501);
      chk("hold_pc", pc_ff_o, pc2);
    end
    id_ready_i = 1'b1;
    step();
    $display("txn resume instr=%h id_pc=%h pc=%h", id_instr_o, id_pc_o, pc_ff_o);
    chk("res_instr", id_instr_o, 32'h0020_8113);
    chk("res_idpc", id_pc_o, pc2);
    chk("res_pc", pc_ff_o, pc2 + 32'd4);

    // prefetch stall: buffer drains, PC holds
    pf_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("txn stall cycle=%0d valid=%b pc=%h", i, id_valid_o, pc_ff_o);
      chk("stall_valid", {31'b0, id_valid_o}, 32'd0);
      chk("stall_pc", pc_ff_o, pc2 + 32'd4);
    end
    chk("stall_instr", id_instr_o, NOP);
    pf_stall_i = 1'b0;

    // refill, then redirect (bit 0 dropped) with same-cycle ack and ready
    pf_instr_i = 32'h0030_0193; id_ready_i = 1'b0;
    step();
    chk("pre_redir_valid", {31'b0, id_valid_o}, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0201; id_ready_i = 1'b1;
    pf_instr_i = 32'h0040_0213;
    step();
    $display("txn redirect pc=%h valid=%b clear=%b", pc_ff_o, id_valid_o, clear_o);
    redirect_i = 1'b0; pf_ack_i = 1'b0;
    chk("redir_valid", {31'b0, id_valid_o}, 32'd0);
    chk("redir_pc", pc_ff_o, 32'h8000_0200);
    chk("redir_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);
    step();
    chk("redir2_clr_req", {30'b0, clear_o, instr_req_o}, 32'b01);
    pf_ack_i = 1'b1;
    step();
    $display("txn acc instr=%h id_pc=%h pc=%h", id_instr_o, id_pc_o, pc_ff_o);
    chk("post_redir_instr", id_instr_o, 32'h0040_0213);
    chk("post_redir_idpc", id_pc_o, 32'h8000_0200);
    chk("post_redir_pc", pc_ff_o, 32'h8000_0204);

    // halfword redirect while buffer full
    pf_ack_i = 1'b0; id_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    step();
    redirect_i = 1'b0;
    $display("txn halfword redirect pc=%h valid=%b mis=%b", pc_ff_o, id_valid_o, id_misalign_o);
    chk("hw_pc", pc_ff_o, 32'h8000_0102);
    if (COMP) begin
      chk("hw_valid", {31'b0, id_valid_o}, 32'd0);
      chk("hw_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);
      step();
      chk("hw2_clr_req", {30'b0, clear_o, instr_req_o}, 32'b01);
    end else begin
      chk("fault_valid", {31'b0, id_valid_o}, 32'd1);
      chk("fault_mis", {31'b0, id_misalign_o}, 32'd1);
      chk("fault_idpc", id_pc_o, 32'h8000_0102);
      chk("fault_instr", id_instr_o, NOP);
      chk("fault_clr_req", {30'b0, clear_o, instr_req_o}, 32'b00);
      pf_ack_i = 1'b1;
      step();
      chk("fault_hold_req", {31'b0, instr_req_o}, 32'd0);
      chk("fault_hold_pc", pc_ff_o, 32'h8000_0102);
      id_ready_i = 1'b1;
      step();
      chk("fault_drain", {31'b0, id_valid_o}, 32'd0);
      chk("fault_drain_req", {31'b0, instr_req_o}, 32'd0);
      pf_ack_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300;
      step();
      redirect_i = 1'b0;
      chk("unfault_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);
      step();
      chk("unfault_req", {30'b0, clear_o, instr_req_o}, 32'b01);
      chk("unfault_pc", pc_ff_o, 32'h8000_0300);
    end

    // asynchronous reset mid-operation
    pf_ack_i = 1'b1; id_ready_i = 1'b1; pf_instr_i = 32'h0050_0293;
    step();
    chk("pre_arst_valid", {31'b0, id_valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("txn async reset pc=%h valid=%b", pc_ff_o, id_valid_o);
    chk("arst_pc", pc_ff_o, 32'h8000_0000);
    chk("arst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("arst_clr_req", {30'b0, clear_o, instr_req_o}, 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch stage sitting directly downstream of the prefetch FIFO and upstream of decode. Owns the architectural fetch PC, drives the request, PC, compressed-length and clear signals into prefetch, and consumes prefetch's instruction/ack/stall response. Accepted instructions are registered into a single-entry output buffer with a valid/ready handshake toward decode. Redirects from execute/CSR flush the stage and prefetch.

## Interface
Parameters:
- PC_RESET, 32'h8000_0000, fetch PC after reset
- INSTR_NOP, 32'h0000_0013, instruction word driven when output invalid

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- pf_instr_i  in  32  instruction from prefetch (halfword-realigned)
- pf_ack_i  in  1  pf_instr_i is valid for pc_ff_o this cycle
- pf_stall_i  in  1  prefetch not ready (FIFO filling or PC mismatch)
- instr_req_o  out  1  fetch request to prefetch
- pc_ff_o  out  32  current fetch PC
- is_comp_o  out  1  pf_instr_i[1:0] != 2'b11 (see Configuration)
- clear_o  out  1  flush prefetch FIFO
- redirect_i  in  1  redirect request (branch/jump/trap)
- redirect_pc_i  in  32  redirect target
- id_ready_i  in  1  decode accepts output this cycle
- id_valid_o  out  1  output buffer holds an instruction
- id_instr_o  out  32  buffered instruction
- id_pc_o  out  32  PC of buffered instruction
- id_comp_o  out  1  buffered instruction is 16-bit
- id_misalign_o  out  1  buffered entry is an instruction-address-misaligned fault

## Operation
- FSM states: S_RESET, S_FETCH, S_FLUSH, S_FAULT. Reset state S_RESET.
- S_RESET: clear_o=1, instr_req_o=0; next cycle -> S_FETCH.
- S_FETCH: instr_req_o=1, clear_o=0. Accept = pf_ack_i & ~pf_stall_i & (~id_valid_o | id_ready_i) & ~redirect_i.
- On accept: output buffer <= {pf_instr_i, pc_ff, is_comp}, id_valid_o<=1; pc_ff <= pc_ff + (is_comp ? 2 : 4), 32-bit wraparound.
- No accept and id_ready_i & id_valid_o: id_valid_o<=0, id_instr_o<=INSTR_NOP.
- Buffer full and ~id_ready_i: buffer and pc_ff hold; pf data ignored.
- redirect_i (any state, highest priority): pc_ff <= {redirect_pc_i[31:1],1'b0}; id_valid_o<=0; same-cycle pf data discarded; -> S_FLUSH.
- S_FLUSH: clear_o=1, instr_req_o=0; -> S_FETCH.
- S_FAULT: instr_req_o=0, clear_o=0; holds until redirect_i. Buffer drains normally.
- is_comp_o is combinational from pf_instr_i, gated by pf_ack_i (0 when no ack).

## Timing
- Reset outputs: pc_ff_o=PC_RESET, id_valid_o=0, id_instr_o=INSTR_NOP, id_pc_o=PC_RESET, id_comp_o=0, id_misalign_o=0, clear_o=1, instr_req_o=0.
- Accept-to-id_valid_o latency: 1 cycle. Sustained throughput 1 instr/cycle with id_ready_i high.
- Redirect in cycle N: clear_o high in N+1; first request with new PC in N+2.
- Simultaneous redirect and id_ready_i: buffer invalidated regardless.
- Reset asserted mid-operation: all state returns to reset values asynchronously.

## Configuration
- FETCH_COMP_EN defined: compressed support as above; pc_ff increments 2 or 4; halfword redirects legal.
- FETCH_COMP_EN undefined: is_comp_o and id_comp_o tied 0; pc_ff always +4. Redirect with redirect_pc_i[1]=1 -> next cycle buffer loads id_misalign_o=1, id_instr_o=INSTR_NOP, id_pc_o=target, id_valid_o=1; FSM -> S_FAULT (no clear, no request).

## Test plan
- Reset release -> clear_o=1 one cycle, then instr_req_o=1, pc_ff_o=32'h8000_0000, id_valid_o=0.
- Ack 32'h00A0_0093 then 16-bit 32'h0000_4501 with id_ready_i=1 -> id_pc_o 0x8000_0000 then 0x8000_0004, pc_ff_o 0x8000_0006, id_comp_o 0 then 1.
- id_ready_i=0 with buffer full, pf_ack_i=1 -> id_instr_o, pc_ff_o stable until ready; then resumes without loss or duplication.
- pf_stall_i=1 for 3 cycles -> no accept, pc_ff_o constant, id_valid_o drops after drain.
- redirect_i with redirect_pc_i=0x8000_0102 while buffer full -> id_valid_o=0 next cycle, clear_o=1 for one cycle, pc_ff_o=0x8000_0102, request resumes at N+2.
- FETCH_COMP_EN off, redirect to 0x8000_0102 -> id_misalign_o=1, id_pc_o=0x8000_0102, instr_req_o=0 until next redirect.
